seg7_scan_ctrl: RTL

Scan controller for the multiplexed seven-segment display on the Nexys3 board. It holds one data register per digit, which a user-side write port loads. It time-multiplexes the digits onto the shared `an`/`seg` pins with a programmable dwell time per digit. A blanking gap between digits suppresses ghosting. It sits between board-level logic and the display pins, and replaces ad-hoc clock-divider/case scanning in top-level modules.

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_hex_decode.sv | 43 ++++
 rtl/seg7_scan_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan controller:
//   - scan_state_e : scan FSM states (BLANK gap, DRIVE one digit)
//   - SEG_OFF      : all-segments-off value on the active-low seg pins
//   - BLANK_CODE_* : digit register reset value for hex and raw data modes
//   - WR_*_BIT     : positions of the dp / blank flags in hex-mode wr_data
// ---------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [7:0] SEG_OFF        = 8'hFF;

  localparam logic [7:0] BLANK_CODE_HEX = 8'h20;
  localparam logic [7:0] BLANK_CODE_RAW = 8'h00;

  localparam int WR_DP_BIT    = 4;
  localparam int WR_BLANK_BIT = 5;

endpackage

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex-digit glyph decoder for a seven-segment display.
// Ports:
//   nibble  in  4  hex value 0..F
//   dp      in  1  decimal point on
//   blank   in  1  force the whole digit dark (overrides nibble and dp)
//   pattern out 8  active-high {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_hex_decode (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] pattern
);

  logic [6:0] glyph;

  always_comb begin
    glyph = 7'h00;
    case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
    pattern = blank ? 8'h00 : {dp, glyph};
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Scan controller for a multiplexed seven-segment display. Holds one data
// register per digit (loaded through a simple write port) and time-multiplexes
// the digits onto shared anode/segment pins, with an optional all-dark gap
// between digits to suppress ghosting.
//
// Build option: define SEG7_HEX_DECODE_EN for hex mode (wr_data[3:0] nibble,
// [4] dp, [5] blank). Without it wr_data is a raw active-high {dp,g..a}
// pattern.
//
// Parameters:
//   NUM_DIGITS   digits scanned (width of an, digit_en; wr_addr is its clog2)
//   PRESCALE     clk cycles each digit is driven (>= 1)
//   BLANK_CYCLES clk cycles of all-anodes-off between digits (0 = no gap)
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   wr_en      in   digit register write strobe
//   wr_addr    in   digit index to write (out-of-range writes are dropped)
//   wr_data    in   digit data (hex or raw, see above)
//   digit_en   in   per-digit enable; a disabled digit keeps its time slot
//   an         out  anode drives, active-low, registered
//   seg        out  {dp,g,f,e,d,c,b,a}, active-low, registered
//   frame_tick out  one-cycle pulse in the cycle idx returns to 0
// For NUM_DIGITS = 1 the address port is kept 1 bit wide.
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  scan_state_e     state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            wrap;

  logic [7:0]      digit_reg [NUM_DIGITS];
  logic [7:0]      cur_data;
  logic [7:0]      cur_pat;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [7:0]      seg_nxt;

  // Outputs are registered from the next-state view, so the pins change on
  // the same edge as the FSM rather than one cycle behind it.
  assign cur_data = digit_reg[idx_nxt];

`ifdef SEG7_HEX_DECODE_EN
  localparam logic [7:0] BLANK_CODE = BLANK_CODE_HEX;

  // Bits 7:6 carry no meaning in hex mode.
  logic unused_hi_bits;
  assign unused_hi_bits = ^cur_data[7:6];

  seg7_hex_decode u_hex_decode (
    .nibble  (cur_data[3:0]),
    .dp      (cur_data[WR_DP_BIT]),
    .blank   (cur_data[WR_BLANK_BIT]),
    .pattern (cur_pat)
  );
`else
  localparam logic [7:0] BLANK_CODE = BLANK_CODE_RAW;

  assign cur_pat = cur_data;
`endif

  // Digit register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_reg[i] <= BLANK_CODE;
      end
    end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      digit_reg[wr_addr] <= wr_data;
    end
  end

  // Scan FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK;
      idx   <= '0;
      cnt   <= CW'(BLANK_CYCLES);
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Scan FSM next-state logic. cnt holds the cycles left in the current
  // phase; a value of 1 (or 0 when blanking is disabled) ends the phase.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap      = 1'b0;
    case (state)
      BLANK: begin
        if (cnt <= CW'(1)) begin
          state_nxt = DRIVE;
          cnt_nxt   = CW'(PRESCALE);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DRIVE: begin
        if (cnt <= CW'(1)) begin
          if (idx == AW'(NUM_DIGITS - 1)) begin
            idx_nxt = '0;
            wrap    = 1'b1;
          end else begin
            idx_nxt = idx + AW'(1);
          end
          if (BLANK_CYCLES == 0) begin
            state_nxt = DRIVE;
            cnt_nxt   = CW'(PRESCALE);
          end else begin
            state_nxt = BLANK;
            cnt_nxt   = CW'(BLANK_CYCLES);
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = CW'(BLANK_CYCLES);
      end
    endcase
  end

  // Pin values for the upcoming cycle; anode and segments share idx_nxt so
  // they can never disagree about which digit is shown.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    if (state_nxt == DRIVE) begin
      an_nxt[idx_nxt] = ~digit_en[idx_nxt];
      seg_nxt         = ~cur_pat;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_tick <= wrap;
    end
  end

endmodule
